mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 17, giving the RAM byte-address width (2^ADDR_BITS bytes).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving TX byte-FIFO entries; power of 2, >=2.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port r_or_w  in  1  request direction: 0 read, 1 write.
REQ-006 SHALL have port a_in  in  32  byte address, presented every cycle.
REQ-007 SHALL have port d_in  in  8  write data byte.
REQ-008 SHALL have port d_out  out  8  registered read data byte.
REQ-009 SHALL have port io_buffer_full  out  1  TX FIFO near-full back-pressure to initiator.
REQ-010 SHALL have ports tx_valid out 1, tx_data out 8, tx_ready in 1: TX byte stream to host/UART.
REQ-011 SHALL have ports rx_valid in 1, rx_data in 8, rx_pop out 1: RX byte source from host.
REQ-012 SHALL have port sim_end  out  1  sticky program-end flag.

Function
REQ-013 SHALL decode IO region as a_in[31:16]==16'h0003; all other addresses map to RAM index a_in[ADDR_BITS-1:0] (upper bits aliased).
REQ-014 SHALL, on r_or_w=1 and RAM address, write d_in to RAM at that posedge.
REQ-015 SHALL, on r_or_w=0 and RAM address, drive d_out with RAM[addr] in the following cycle (1-cycle read latency, one byte per cycle, back-to-back).
REQ-016 SHALL, on r_or_w=1 and a_in==32'h30000, push d_in into the TX FIFO if count<FIFO_DEPTH or a pop occurs in the same cycle; otherwise drop the byte.
REQ-017 SHALL drive tx_valid=(count!=0), tx_data=FIFO head; pop when tx_valid&&tx_ready.
REQ-018 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-019 SHALL drive io_buffer_full=1 when count>=FIFO_DEPTH-1 (one-slot guard for the initiator's one-cycle sampling lag), else 0, derived from registered count.
REQ-020 SHALL, on r_or_w=0 and a_in==32'h30000, drive d_out next cycle per REQ-027/REQ-028.
REQ-021 SHALL, on r_or_w=1 and a_in==32'h30004, set sim_end=1, held until reset.
REQ-022 SHALL return d_out=8'h00 next cycle for reads of any IO address other than 32'h30000.
REQ-023 SHALL ignore writes to IO addresses other than 32'h30000/32'h30004 (no RAM write).
REQ-024 SHALL treat idle cycles (r_or_w=0, a_in=0) as ordinary RAM reads with no side effect.

Reset
REQ-025 SHALL, while rst=1, clear d_out=0, FIFO pointers/count=0, tx_valid=0, io_buffer_full=0, rx_pop=0, sim_end=0; FIFO contents discarded even mid-stream.
REQ-026 SHALL NOT reset RAM contents.

Configuration
REQ-027 SHALL, with macro MEM_IO_RX_EN defined, on a read of 32'h30000 return rx_data next cycle if rx_valid else 8'h00, and pulse rx_pop=1 for exactly the request cycle when rx_valid=1.
REQ-028 SHALL, without MEM_IO_RX_EN, return 8'h00 for reads of 32'h30000, tie rx_pop=0, ignore rx_valid/rx_data.

Structure
REQ-029 SHALL take IO_UART_ADDR (32'h30000), IO_END_ADDR (32'h30004) and IO_REGION_HI (16'h0003) from the shared info package/header.
REQ-030 SHALL implement the TX FIFO as sub-module resp_tx_fifo (push, pop, head, count, full).

Verification
REQ-031 SHALL check: write 8'hA5 to 0x00010, then read 0x00010 -> d_out==8'hA5 one cycle after the read request.
REQ-032 SHALL check: read bytes 0x100..0x103 back-to-back holding 11,22,33,44 -> d_out 11,22,33,44 on consecutive cycles.
REQ-033 SHALL check: tx_ready=0, 7 writes to 0x30000 -> io_buffer_full=1 after 7th; 9th and later writes dropped; tx_ready=1 drains exactly 8 bytes in order.
REQ-034 SHALL check: count=8, simultaneous push 8'h5A and pop -> count stays 8, 8'h5A emerges last.
REQ-035 SHALL check: write 0x30004 -> sim_end=1 next cycle, stays 1 until rst; rst mid-drain -> tx_valid=0 next cycle.
REQ-036 SHALL check (MEM_IO_RX_EN): rx_valid=1, rx_data=8'h3C, read 0x30000 -> rx_pop one-cycle pulse, d_out==8'h3C; without macro d_out==0, rx_pop stays 0.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory / IO responder.
// Holds the IO map constants and the request classification used by the top level.
package mem_io_responder_pkg;

    // IO map: the whole 0x0003_xxxx window is IO space, two addresses are live.
    localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
    localparam logic [31:0] IO_END_ADDR  = 32'h0003_0004;
    localparam logic [15:0] IO_REGION_HI = 16'h0003;

    // Classification of a single request cycle.
    typedef enum logic [2:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_UART_RD,
        ACC_UART_WR,
        ACC_END_WR,
        ACC_IO_RD,
        ACC_IO_WR
    } access_e;

    // Turns direction + address into an access kind. Reads of unmapped IO
    // addresses and writes to them get their own kinds so that neither one
    // can fall through to the RAM.
    function automatic access_e decode_access(input logic i_write, input logic [31:0] i_addr);
        access_e v_kind;
        if (i_addr[31:16] == IO_REGION_HI) begin
            if (i_write) begin
                if (i_addr == IO_UART_ADDR) begin
                    v_kind = ACC_UART_WR;
                end else if (i_addr == IO_END_ADDR) begin
                    v_kind = ACC_END_WR;
                end else begin
                    v_kind = ACC_IO_WR;
                end
            end else begin
                if (i_addr == IO_UART_ADDR) begin
                    v_kind = ACC_UART_RD;
                end else begin
                    v_kind = ACC_IO_RD;
                end
            end
        end else begin
            v_kind = i_write ? ACC_RAM_WR : ACC_RAM_RD;
        end
        return v_kind;
    endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// resp_tx_fifo: byte FIFO feeding the TX stream.
// DEPTH must be a power of two (>= 2) so the pointers wrap by plain overflow.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module resp_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop only happens when there is something to pop; a push needs room
    // unless the head is leaving in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && (!o_full || w_pop);

    // Storage array; contents are don't-care once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; reset drops anything still queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus a tiny IO window for a simulated core.
//   0x0003_0000 write -> TX FIFO byte, read -> RX byte (or 0)
//   0x0003_0004 write -> sticky sim_end
//   other 0x0003_xxxx -> reads return 0, writes ignored
//   everything else   -> RAM, index a_in[ADDR_BITS-1:0]
// Optional feature macro: MEM_IO_RX_EN enables the RX byte path on reads of
// 0x0003_0000. Without it those reads return 0 and rx_pop stays low.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_or_w,
    input  logic [31:0] a_in,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        sim_end
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    access_e              w_access;
    logic [ADDR_BITS-1:0] w_ram_idx;
    logic [7:0]           w_rx_byte;
    logic [CW-1:0]        w_count;
    logic                 w_fifo_full;
    logic [7:0]           w_head;

    logic [7:0]           r_ram [2**ADDR_BITS];
    logic [7:0]           r_d_out;
    logic                 r_sim_end;

    assign w_access  = decode_access(r_or_w, a_in);
    assign w_ram_idx = a_in[ADDR_BITS-1:0];

`ifdef MEM_IO_RX_EN
    // The host byte is consumed in the very cycle the core asks for it.
    assign w_rx_byte = rx_valid ? rx_data : 8'h00;
    assign rx_pop    = !rst && (w_access == ACC_UART_RD) && rx_valid;
`else
    logic w_unused_rx;
    assign w_rx_byte   = 8'h00;
    assign rx_pop      = 1'b0;
    assign w_unused_rx = ^{rx_valid, rx_data};
`endif

    // RAM write port; the array is never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_access == ACC_RAM_WR) begin
            r_ram[w_ram_idx] <= d_in;
        end
    end

    // Read data register: one-cycle latency for every kind of read, holds on writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out <= 8'h00;
        end else begin
            case (w_access)
                ACC_RAM_RD:  r_d_out <= r_ram[w_ram_idx];
                ACC_UART_RD: r_d_out <= w_rx_byte;
                ACC_IO_RD:   r_d_out <= 8'h00;
                default:     r_d_out <= r_d_out;
            endcase
        end
    end

    // Program-end flag latches on the first write to the end address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sim_end <= 1'b0;
        end else if (w_access == ACC_END_WR) begin
            r_sim_end <= 1'b1;
        end
    end

    resp_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_access == ACC_UART_WR),
        .i_data  (d_in),
        .i_pop   (tx_ready),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_fifo_full)
    );

    // Back-pressure asserts one slot early because the initiator sees it a
    // cycle late and may already have the next write in flight.
    assign io_buffer_full = w_fifo_full || (w_count == CW'(FIFO_DEPTH - 1));
    assign tx_valid       = (w_count != '0);
    assign tx_data        = w_head;
    assign d_out          = r_d_out;
    assign sim_end        = r_sim_end;

endmodule
